buf_drain: RTL and testbench
============================

# buf_drain

Reader end of the buffered-register handoff. It watches a producer's holding register (two data words plus a `flag` valid bit) and captures each pair into a DEPTH-entry FIFO. It acknowledges each capture with a one-cycle `buf_ack` pulse so the producer clears its flag, then presents the pairs to a downstream core in order under its own `read`/`stall` control. It sits between an inter-core buffer register and the consuming pipeline stage.

## Interface
- `WIDTH`, 32: width of each data word.
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `Clk` in 1: single clock; all state updates on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `buf_in_1`, `buf_in_2` in WIDTH: producer register data.
- `buf_flag` in 1: producer register holds an unconsumed pair.
- `buf_ack` out 1: registered one-cycle pulse meaning "pair captured". The producer clears `buf_flag` on the edge that ends this cycle.
- `read` in 1: consumer requests a pop.
- `stall` in 1: blocks a pop in the current cycle.
- `out_1`, `out_2` out WIDTH: head-of-FIFO pair, show-ahead; 0 when empty.
- `valid` out 1: FIFO not empty.
- `full` out 1: count == DEPTH.
- `count` out clog2(DEPTH)+1: number of occupied entries.

## Operation
- Storage: two DEPTH×WIDTH arrays, plus `wr_ptr` and `rd_ptr` of clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH. `count` is kept as a separate register.
- `pop` = `read & ~stall & valid`. A `read` while empty, or while `stall` is high, has no effect.
- Capture FSM states:
  - IDLE → ACK when `buf_flag & (~full | pop)`. On that edge:
    - write `{buf_in_1, buf_in_2}` at `wr_ptr`;
    - advance `wr_ptr`;
    - set `buf_ack` to 1.
  - IDLE stays IDLE otherwise. `buf_flag` stays pending; no data is lost or overwritten.
  - ACK → IDLE unconditionally. `buf_ack` returns to 0 and nothing is captured in ACK. This stops the still-high `buf_flag` from being captured twice.
- `count` update: +1 on capture only, −1 on pop only, unchanged when both happen or neither happens.
- Full with a simultaneous pop: the capture is allowed and `count` stays at DEPTH.
- Empty with a simultaneous capture: no pop is possible that cycle. The new entry becomes visible on `out_1`/`out_2` the following cycle.
- Reset:
  - pointers, `count`, `buf_ack` and all FIFO state cleared to 0; FSM to IDLE;
  - `valid` = 0, `full` = 0, `out_1` = `out_2` = 0;
  - array contents need not be cleared.
- Reset in the ACK state drops `buf_ack` on that edge. The producer's flag stays set and the pair is recaptured after reset.

## Timing
- Capture latency: `buf_flag` high in cycle N (state IDLE, room available) → `buf_ack` = 1 and `valid` = 1 in cycle N+1.
- Producer handshake: the producer clears its flag at the end of cycle N+1, so `buf_flag` = 0 from cycle N+2. A new pair written by the producer in N+2 is captured at the end of N+2.
- Peak capture rate: one pair per 2 cycles.
- Pop: pop at the end of cycle M → the next entry (or zeros if now empty) is on the outputs in cycle M+1.
- `buf_ack` is never high in two consecutive cycles.
- `buf_ack` is never asserted unless `buf_flag` was high in the previous cycle.
- `valid`, `full`, `out_1`, `out_2` derive combinationally from registered state only; no input-to-output combinational path.

## Test plan
- **Reset and single pass:** after Reset, `buf_flag` = 1 with 0xAAAA0001 / 0xBBBB0001.
  - `buf_ack` pulses exactly one cycle later.
  - `valid` = 1, `out_1` = 0xAAAA0001, `out_2` = 0xBBBB0001, `count` = 1.
  - `read` = 1 for one cycle → `valid` = 0, outputs 0.
- **Fill to full:** producer supplies 5 pairs, `read` = 0.
  - 4 `buf_ack` pulses, 2 cycles apart.
  - `full` = 1, `count` = 4.
  - 5th `buf_flag` stays high with no ack.
  - One pop → 5th pair captured on that same edge; `count` stays 4.
- **Stall:** `full` with `read` = 1, `stall` = 1 for 3 cycles.
  - No pop, outputs unchanged, no `buf_ack`.
  - Drop `stall` → pop, followed by capture.
- **Wrap-around:** stream 10 pairs with `read` held high.
  - Output order matches input order across pointer wrap.
  - `count` never exceeds 1.
- **Double-capture guard:** producer holds `buf_flag` high for 3 cycles (slow clear).
  - Only one `buf_ack` and one FIFO entry in the first 2 cycles.
  - A second capture occurs in cycle 3; the bench flags this as a producer protocol violation.
- **Reset mid-ACK:** assert Reset in the cycle `buf_ack` = 1.
  - Next cycle: `buf_ack` = 0, `count` = 0, `valid` = 0.
  - `buf_flag` still high → pair recaptured 1 cycle after Reset deasserts.

Source files
------------

// File: rtl/buf_drain.sv
// Reader end of a buffered-register handoff: captures producer pairs into a small FIFO,
// acknowledges each capture with a one-cycle pulse and presents pairs show-ahead to the consumer.
module buf_drain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [WIDTH-1:0]         buf_in_1,
  input  logic [WIDTH-1:0]         buf_in_2,
  input  logic                     buf_flag,
  output logic                     buf_ack,
  input  logic                     read,
  input  logic                     stall,
  output logic [WIDTH-1:0]         out_1,
  output logic [WIDTH-1:0]         out_2,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StAck} state_e;

  state_e            state_q;
  logic              buf_ack_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  mem1_q [DEPTH];
  logic [WIDTH-1:0]  mem2_q [DEPTH];

  logic pop;
  logic capture;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign pop     = read & ~stall & valid;
  // A pop on the same edge frees the slot, so a full FIFO can still accept the pending pair.
  assign capture = (state_q == StIdle) & buf_flag & (~full | pop);

  assign out_1   = valid ? mem1_q[rd_ptr_q] : '0;
  assign out_2   = valid ? mem2_q[rd_ptr_q] : '0;
  assign count   = count_q;
  assign buf_ack = buf_ack_q;

  always_comb begin
    count_d = count_q;
    case ({capture, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // The ACK state blanks one cycle so the producer's still-high flag is not captured twice.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      buf_ack_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (capture) begin
            state_q   <= StAck;
            buf_ack_q <= 1'b1;
          end else begin
            buf_ack_q <= 1'b0;
          end
        end
        StAck: begin
          state_q   <= StIdle;
          buf_ack_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          buf_ack_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (capture) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (capture && !Reset) begin
      mem1_q[wr_ptr_q] <= buf_in_1;
      mem2_q[wr_ptr_q] <= buf_in_2;
    end
  end

endmodule

// File: tb/tb_buf_drain.sv
// Randomised bench for buf_drain: a queue-based FIFO/handshake model predicts every cycle.
module tb_buf_drain;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  typedef logic [2*WIDTH-1:0] pair_t;

  logic             Clk;
  logic             Reset;
  logic [WIDTH-1:0] buf_in_1, buf_in_2;
  logic             buf_flag;
  logic             buf_ack;
  logic             read, stall;
  logic [WIDTH-1:0] out_1, out_2;
  logic             valid, full;
  logic [CntW-1:0]  count;

  buf_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .buf_in_1 (buf_in_1),
    .buf_in_2 (buf_in_2),
    .buf_flag (buf_flag),
    .buf_ack  (buf_ack),
    .read     (read),
    .stall    (stall),
    .out_1    (out_1),
    .out_2    (out_2),
    .valid    (valid),
    .full     (full),
    .count    (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored pairs plus the expected ack of the current cycle.
  pair_t mq[$];
  pair_t prod_q[$];
  bit    exp_ack  = 1'b0;
  bit    prev_ack = 1'b0;
  bit    prod_en  = 1'b0;

  function automatic pair_t head();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  // One clock cycle: producer reacts, model predicts, edge, model updates. No checking here.
  task automatic tick();
    bit do_pop, do_cap;
    if (prod_en) begin
      if (prev_ack) buf_flag = 1'b0;
      if (!buf_flag && prod_q.size() > 0) begin
        {buf_in_1, buf_in_2} = prod_q.pop_front();
        buf_flag = 1'b1;
      end
    end
    do_pop = read && !stall && (mq.size() > 0);
    do_cap = buf_flag && !exp_ack && ((mq.size() < DEPTH) || do_pop);
    @(posedge Clk);
    #1;
    prev_ack = exp_ack;
    if (Reset) begin
      mq.delete();
      exp_ack = 1'b0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_cap) mq.push_back({buf_in_1, buf_in_2});
      exp_ack = do_cap;
    end
  endtask

  task automatic drain();
    read = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) tick();
    read = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    checks++;
    if (buf_ack !== 1'b0 || valid !== 1'b0 || full !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got ack=%b valid=%b full=%b count=%0d want 0/0/0/0",
               buf_ack, valid, full, count);
    end
    checks++;
    if (out_1 !== '0 || out_2 !== '0) begin
      errors++;
      $display("FAIL reset_out: got %h/%h want 0/0", out_1, out_2);
    end
  endtask

  task automatic test_single();
    prod_en = 1'b1;
    prod_q.push_back({32'hAAAA0001, 32'hBBBB0001});
    tick();
    checks++;
    if (buf_ack !== 1'b1 || valid !== 1'b1 || count !== CntW'(1)) begin
      errors++;
      $display("FAIL single_ack: got ack=%b valid=%b count=%0d want 1/1/1", buf_ack, valid, count);
    end
    checks++;
    if (out_1 !== 32'hAAAA0001 || out_2 !== 32'hBBBB0001) begin
      errors++;
      $display("FAIL single_data: got %h/%h want aaaa0001/bbbb0001", out_1, out_2);
    end
    tick();
    checks++;
    if (buf_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_width: got %b want 0", buf_ack);
    end
    read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (valid !== 1'b0 || out_1 !== '0 || out_2 !== '0) begin
      errors++;
      $display("FAIL single_pop: got valid=%b %h/%h want 0 0/0", valid, out_1, out_2);
    end
  endtask

  task automatic test_fill();
    int acks;
    bit last;
    acks = 0;
    last = 1'b0;
    prod_en = 1'b1;
    for (int i = 0; i < 5; i++) prod_q.push_back({$urandom(), $urandom()});
    for (int i = 0; i < 10; i++) begin
      tick();
      if (buf_ack === 1'b1) acks++;
      checks++;
      if (buf_ack === 1'b1 && last) begin
        errors++;
        $display("FAIL fill_ack_back_to_back: cycle %0d got two consecutive acks", i);
      end
      last = (buf_ack === 1'b1);
    end
    checks++;
    if (acks != 4) begin
      errors++;
      $display("FAIL fill_ack_count: got %0d want 4", acks);
    end
    checks++;
    if (full !== 1'b1 || count !== CntW'(DEPTH) || buf_flag !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got full=%b count=%0d flag=%b want 1/%0d/1",
               full, count, buf_flag, DEPTH);
    end
    checks++;
    if ({out_1, out_2} !== head()) begin
      errors++;
      $display("FAIL fill_head: got %h want %h", {out_1, out_2}, head());
    end
    read = 1'b1;
    tick();
    read = 1'b0;
    checks++;
    if (buf_ack !== 1'b1 || count !== CntW'(DEPTH)) begin
      errors++;
      $display("FAIL fill_pop_capture: got ack=%b count=%0d want 1/%0d", buf_ack, count, DEPTH);
    end
    checks++;
    if ({out_1, out_2} !== head()) begin
      errors++;
      $display("FAIL fill_next_head: got %h want %h", {out_1, out_2}, head());
    end
    drain();
  endtask

  task automatic test_stall();
    pair_t hold;
    prod_en = 1'b1;
    for (int i = 0; i < 5; i++) prod_q.push_back({$urandom(), $urandom()});
    for (int i = 0; i < 10; i++) tick();
    hold = {out_1, out_2};
    read = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_1, out_2} !== hold || count !== CntW'(DEPTH) || buf_ack !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got %h count=%0d ack=%b want %h %0d 0",
                 i, {out_1, out_2}, count, buf_ack, hold, DEPTH);
      end
    end
    stall = 1'b0;
    tick();
    read = 1'b0;
    checks++;
    if (buf_ack !== 1'b1 || count !== CntW'(DEPTH)) begin
      errors++;
      $display("FAIL stall_release: got ack=%b count=%0d want 1/%0d", buf_ack, count, DEPTH);
    end
    checks++;
    if ({out_1, out_2} !== head() || {out_1, out_2} === hold) begin
      errors++;
      $display("FAIL stall_release_head: got %h want %h", {out_1, out_2}, head());
    end
    drain();
  endtask

  task automatic test_wrap();
    pair_t sent[$];
    pair_t got[$];
    pair_t p;
    prod_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      p = {$urandom(), $urandom()};
      sent.push_back(p);
      prod_q.push_back(p);
    end
    read = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (valid === 1'b1) got.push_back({out_1, out_2});
      tick();
      checks++;
      if (count > CntW'(1) || count !== CntW'(mq.size()) || {out_1, out_2} !== head()) begin
        errors++;
        $display("FAIL wrap_cycle: cycle %0d got count=%0d data=%h want count=%0d data=%h",
                 i, count, {out_1, out_2}, mq.size(), head());
      end
    end
    read = 1'b0;
    checks++;
    if (got.size() != sent.size()) begin
      errors++;
      $display("FAIL wrap_len: got %0d pairs want %0d", got.size(), sent.size());
    end
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== sent[i]) begin
        errors++;
        $display("FAIL wrap_order: index %0d got %h want %h", i, got[i], sent[i]);
      end
    end
  endtask

  task automatic test_double_capture();
    prod_en = 1'b0;
    buf_in_1 = 32'h1234_5678;
    buf_in_2 = 32'h9ABC_DEF0;
    buf_flag = 1'b1;
    tick();
    checks++;
    if (buf_ack !== 1'b1 || count !== CntW'(1)) begin
      errors++;
      $display("FAIL double_first: got ack=%b count=%0d want 1/1", buf_ack, count);
    end
    tick();
    checks++;
    if (buf_ack !== 1'b0 || count !== CntW'(1)) begin
      errors++;
      $display("FAIL double_guard: got ack=%b count=%0d want 0/1", buf_ack, count);
    end
    tick();
    checks++;
    if (buf_ack !== 1'b1 || count !== CntW'(2)) begin
      errors++;
      $display("FAIL double_third: got ack=%b count=%0d want 1/2", buf_ack, count);
    end
    $display("note: producer held flag for 3 cycles - second capture is a producer protocol violation");
    buf_flag = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_ack();
    prod_en = 1'b0;
    buf_in_1 = 32'hCAFE_0001;
    buf_in_2 = 32'hBEEF_0001;
    buf_flag = 1'b1;
    tick();
    checks++;
    if (buf_ack !== 1'b1) begin
      errors++;
      $display("FAIL rst_ack_pre: got %b want 1", buf_ack);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (buf_ack !== 1'b0 || count !== '0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_ack_clear: got ack=%b count=%0d valid=%b want 0/0/0",
               buf_ack, count, valid);
    end
    tick();
    checks++;
    if (buf_ack !== 1'b1 || count !== CntW'(1) || out_1 !== 32'hCAFE_0001
        || out_2 !== 32'hBEEF_0001) begin
      errors++;
      $display("FAIL rst_recapture: got ack=%b count=%0d data=%h/%h want 1/1 cafe0001/beef0001",
               buf_ack, count, out_1, out_2);
    end
    buf_flag = 1'b0;
    drain();
  endtask

  task automatic test_random();
    prod_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      read  = ($urandom_range(0, 2) != 0);
      stall = ($urandom_range(0, 3) == 0);
      if (prod_q.size() < 2 && $urandom_range(0, 1) == 1)
        prod_q.push_back({$urandom(), $urandom()});
      tick();
      checks++;
      if (buf_ack !== exp_ack || count !== CntW'(mq.size())
          || valid !== (mq.size() > 0) || full !== (mq.size() == DEPTH)) begin
        errors++;
        $display("FAIL random_ctrl: cycle %0d got ack=%b count=%0d valid=%b full=%b want %b %0d",
                 i, buf_ack, count, valid, full, exp_ack, mq.size());
      end
      checks++;
      if ({out_1, out_2} !== head()) begin
        errors++;
        $display("FAIL random_data: cycle %0d got %h want %h", i, {out_1, out_2}, head());
      end
    end
    read  = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    buf_in_1 = '0;
    buf_in_2 = '0;
    buf_flag = 1'b0;
    read     = 1'b0;
    stall    = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_wrap();
    test_double_capture();
    test_reset_mid_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
